// File: rtl/pong_match_ctrl.sv
// N-player pong match sequencer: splash, serve countdown, rally, point pause, game over.
// Optional macro WIN_BY_TWO_EN requires a two-point lead to win, unless the scorer is already saturated.
module pong_match_ctrl #(
  parameter int NUM_PLAYERS      = 2,
  parameter int SCORE_W          = 3,
  parameter int WIN_SCORE        = 7,
  parameter int SERVE_TICKS      = 60,
  parameter int POINT_HOLD_TICKS = 30
) (
  input  logic                           clk,
  input  logic                           clr,
  input  logic                           tick,
  input  logic                           start,
  input  logic                           restart,
  input  logic [NUM_PLAYERS-1:0]         point,
  output logic [NUM_PLAYERS*SCORE_W-1:0] scores,
  output logic [2:0]                     cur_state,
  output logic                           ball_en,
  output logic [1:0]                     serve_to,
  output logic [1:0]                     winner,
  output logic                           game_over
);
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_SERVE = 3'd1, S_PLAY = 3'd2, S_POINT = 3'd3, S_OVER = 3'd4
  } state_t;

  localparam int CNT_MAX = (SERVE_TICKS > POINT_HOLD_TICKS) ? SERVE_TICKS : POINT_HOLD_TICKS;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0]      SERVE_LD = CW'(SERVE_TICKS);
  localparam logic [CW-1:0]      HOLD_LD  = CW'(POINT_HOLD_TICKS);
  localparam logic [CW-1:0]      ONE      = CW'(1);
  localparam logic [SCORE_W-1:0] SMAX     = '1;
  localparam logic [SCORE_W-1:0] WIN      = SCORE_W'(WIN_SCORE);

  state_t                              state_q, state_d;
  logic [NUM_PLAYERS-1:0][SCORE_W-1:0] score_q, score_d;
  logic [CW-1:0]                       cnt_q, cnt_d;
  logic [1:0]                          serve_q, serve_d, win_q, win_d;
  logic                                start_q, restart_q;
  logic                                start_rise, restart_rise;

  logic               hit, ends;
  logic [1:0]         pidx;
  logic [SCORE_W-1:0] old_sc, new_sc;

  assign start_rise   = start & ~start_q;
  assign restart_rise = restart & ~restart_q;

  // Lowest-index scorer wins the cycle; simultaneous higher bits are dropped.
  always_comb begin
    hit    = 1'b0;
    pidx   = '0;
    old_sc = '0;
    for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
      if (point[i]) begin
        hit    = 1'b1;
        pidx   = 2'(i);
        old_sc = score_q[i];
      end
    end
    new_sc = (old_sc == SMAX) ? SMAX : old_sc + 1'b1;
`ifdef WIN_BY_TWO_EN
    begin
      logic                 lead_ok;
      logic [SCORE_W:0]     two;
      two     = (SCORE_W+1)'(2);
      lead_ok = 1'b1;
      for (int j = 0; j < NUM_PLAYERS; j++)
        if (2'(j) != pidx && ({1'b0, score_q[j]} + two) > {1'b0, new_sc})
          lead_ok = 1'b0;
      ends = (new_sc >= WIN) && (lead_ok || old_sc == SMAX);
    end
`else
    ends = (new_sc >= WIN);
`endif
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q   <= S_IDLE;
      score_q   <= '0;
      cnt_q     <= '0;
      serve_q   <= '0;
      win_q     <= '0;
    end else begin
      state_q   <= state_d;
      score_q   <= score_d;
      cnt_q     <= cnt_d;
      serve_q   <= serve_d;
      win_q     <= win_d;
    end
    start_q   <= start;
    restart_q <= restart;
  end

  always_comb begin
    state_d = state_q;
    score_d = score_q;
    cnt_d   = cnt_q;
    serve_d = serve_q;
    win_d   = win_q;
    if (restart_rise) begin
      state_d = S_IDLE;
      score_d = '0;
      serve_d = '0;
    end else begin
      case (state_q)
        S_IDLE: if (start_rise) begin
          state_d = S_SERVE;
          cnt_d   = SERVE_LD;
          serve_d = '0;
        end
        S_SERVE: if (tick) begin
          if (cnt_q <= ONE) begin
            state_d = S_PLAY;
            cnt_d   = '0;
          end else cnt_d = cnt_q - ONE;
        end
        S_PLAY: if (hit) begin
          for (int i = 0; i < NUM_PLAYERS; i++)
            if (2'(i) == pidx) score_d[i] = new_sc;
          if (ends) begin
            state_d = S_OVER;
            win_d   = pidx;
          end else begin
            state_d = S_POINT;
            cnt_d   = HOLD_LD;
            serve_d = pidx;
          end
        end
        S_POINT: if (tick) begin
          if (cnt_q <= ONE) begin
            state_d = S_SERVE;
            cnt_d   = SERVE_LD;
          end else cnt_d = cnt_q - ONE;
        end
        S_OVER:  ;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    cur_state = state_q;
    ball_en   = (state_q == S_PLAY);
    game_over = (state_q == S_OVER);
    scores    = score_q;
    serve_to  = serve_q;
    winner    = win_q;
  end
endmodule

// File: tb/tb_pong_match_ctrl.sv
// Directed bench for pong_match_ctrl with a rule-level game model checked every cycle.
module tb_pong_match_ctrl;
  localparam int NP = 2, SW = 3, WS = 3, ST = 2, PH = 2;
  localparam int SMAX = 7;

  logic          clk = 1'b0;
  logic          clr, tick, start, restart;
  logic [NP-1:0] point;
  logic [NP*SW-1:0] scores;
  logic [2:0]    cur_state;
  logic          ball_en, game_over;
  logic [1:0]    serve_to, winner;

  pong_match_ctrl #(
    .NUM_PLAYERS(NP), .SCORE_W(SW), .WIN_SCORE(WS),
    .SERVE_TICKS(ST), .POINT_HOLD_TICKS(PH)
  ) dut (
    .clk(clk), .clr(clr), .tick(tick), .start(start), .restart(restart),
    .point(point), .scores(scores), .cur_state(cur_state), .ball_en(ball_en),
    .serve_to(serve_to), .winner(winner), .game_over(game_over)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Game model: states 0..4 as named in the port description, plain integer scores.
  int m_st = 0, m_cnt = 0, m_srv = 0, m_win = 0;
  int m_sc[NP];
  bit m_sp = 0, m_rp = 0, m_valid = 0;

  always @(posedge clk) begin
    if (clr) begin
      m_valid = 1;
      m_st = 0; m_cnt = 0; m_srv = 0; m_win = 0;
      foreach (m_sc[i]) m_sc[i] = 0;
    end else if (restart && !m_rp) begin
      m_st = 0; m_srv = 0;
      foreach (m_sc[i]) m_sc[i] = 0;
    end else begin
      case (m_st)
        0: if (start && !m_sp) begin m_st = 1; m_cnt = ST; m_srv = 0; end
        1: if (tick) begin
             m_cnt--;
             if (m_cnt <= 0) m_st = 2;
           end
        2: if (point != 0) begin
             int p, ns, old;
             bit done;
             p = 0;
             while (!point[p]) p++;
             old = m_sc[p];
             ns = (old + 1 > SMAX) ? SMAX : old + 1;
             m_sc[p] = ns;
             done = (ns >= WS);
`ifdef WIN_BY_TWO_EN
             if (old != SMAX)
               for (int j = 0; j < NP; j++)
                 if (j != p && ns - m_sc[j] < 2) done = 0;
`endif
             if (done) begin m_st = 4; m_win = p; end
             else begin m_st = 3; m_cnt = PH; m_srv = p; end
           end
        3: if (tick) begin
             m_cnt--;
             if (m_cnt <= 0) begin m_st = 1; m_cnt = ST; end
           end
        default: ;
      endcase
    end
    m_sp = start;
    m_rp = restart;
  end

  always @(negedge clk) begin
    if (m_valid) begin
      logic [NP*SW-1:0] exp_sc;
      for (int i = 0; i < NP; i++) exp_sc[i*SW +: SW] = SW'(m_sc[i]);
      check("m_state", 32'(cur_state), 32'(m_st));
      check("m_scores", 32'(scores), 32'(exp_sc));
      check("m_ball_en", 32'(ball_en), 32'(m_st == 2));
      check("m_game_over", 32'(game_over), 32'(m_st == 4));
      check("m_serve_to", 32'(serve_to), 32'(m_srv));
      check("m_winner", 32'(winner), 32'(m_win));
    end
  end

  task automatic tk();
    @(posedge clk);
    #2;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1; tk(); tick = 1'b0;
    end
  endtask

  task automatic pt(input logic [NP-1:0] v);
    point = v; tk(); point = '0;
  endtask

  task automatic start_rise();
    start = 1'b0; tk(); start = 1'b1; tk();
  endtask

  // From PLAY: score one point and, if the match goes on, come back to PLAY.
  task automatic play_point(input int p);
    pt(NP'(1 << p));
    if (m_st == 3) ticks(PH + ST);
  endtask

  initial begin
    clr = 1'b1; start = 1'b1; restart = 1'b0; tick = 1'b0; point = '0;
    tk(); tk();
    check("rst_state", 32'(cur_state), 0);
    check("rst_scores", 32'(scores), 0);
    check("rst_game_over", 32'(game_over), 0);
    clr = 1'b0;
    tk(); tk();
    check("no_edge_after_clr", 32'(cur_state), 0);

    start_rise();
    check("start_to_serve", 32'(cur_state), 1);
    check("serve_ball_off", 32'(ball_en), 0);
    ticks(1);
    check("serve_1st_tick", 32'(cur_state), 1);
    ticks(1);
    check("play_2nd_tick", 32'(cur_state), 2);
    check("play_ball_on", 32'(ball_en), 1);

    pt(2'b11);
    check("dual_point_scores", 32'(scores), 32'b000_001);
    check("dual_point_state", 32'(cur_state), 3);
    check("dual_point_serve", 32'(serve_to), 0);
    ticks(2);
    check("hold_to_serve", 32'(cur_state), 1);

    for (int k = 0; k < 3; k++) begin
      ticks(2);
      pt(2'b10);
      if (k < 2) ticks(2);
    end
    check("p1_win_scores", 32'(scores), 32'b011_001);
    check("p1_win_state", 32'(cur_state), 4);
    check("p1_winner", 32'(winner), 1);
    check("p1_game_over", 32'(game_over), 1);
    start_rise();
    pt(2'b01);
    check("over_start_ignored", 32'(cur_state), 4);
    check("over_scores_frozen", 32'(scores), 32'b011_001);

    restart = 1'b1; tk(); restart = 1'b0;
    check("restart_from_over", 32'(cur_state), 0);
    check("restart_game_over", 32'(game_over), 0);

    start = 1'b0; tk();
    start = 1'b1; tick = 1'b1; tk(); tick = 1'b0;
    check("tick_start_same", 32'(cur_state), 1);
    ticks(1);
    check("tick_not_counted", 32'(cur_state), 1);
    ticks(1);
    check("serve_done", 32'(cur_state), 2);

    play_point(0);
    play_point(1);
    pt(2'b10);
    pt(2'b01);
    check("point_ignored_hold", 32'(scores), 32'b010_001);
    ticks(2);
    ticks(1);
    pt(2'b01);
    check("point_ignored_serve", 32'(scores), 32'b010_001);
    check("mid_serve", 32'(cur_state), 1);
    restart = 1'b1; tk(); restart = 1'b0;
    check("restart_mid_serve", 32'(cur_state), 0);
    check("restart_scores", 32'(scores), 0);
    check("restart_serve_to", 32'(serve_to), 0);

`ifdef WIN_BY_TWO_EN
    start_rise(); ticks(2);
    play_point(0); play_point(1); play_point(0); play_point(1);
    pt(2'b01);
    check("w2_3_2_state", 32'(cur_state), 3);
    check("w2_3_2_scores", 32'(scores), 32'b010_011);
    ticks(4);
    pt(2'b01);
    check("w2_4_2_state", 32'(cur_state), 4);
    check("w2_4_2_winner", 32'(winner), 0);
    check("w2_4_2_scores", 32'(scores), 32'b010_100);

    restart = 1'b1; tk(); restart = 1'b0;
    start_rise(); ticks(2);
    for (int k = 0; k < 6; k++) begin play_point(0); play_point(1); end
    pt(2'b01);
    check("w2_7_6_state", 32'(cur_state), 3);
    check("w2_7_6_scores", 32'(scores), 32'b110_111);
    ticks(4);
    pt(2'b01);
    check("w2_sat_state", 32'(cur_state), 4);
    check("w2_sat_winner", 32'(winner), 0);
    check("w2_sat_scores", 32'(scores), 32'b110_111);
`endif

    tk(); tk();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
